// File: rtl/tmr_input_conditioner_pkg.sv
// Shared definitions for the TMR input conditioner: FSM encoding, channel
// indices and the odd-channel helper used by the fault tracker.
package tmr_input_conditioner_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;

    // Only meaningful when the three values are not all equal; the channel
    // that disagrees with the other two is returned.
    function automatic logic [1:0] odd_channel(input logic a, input logic b, input logic c);
        logic [1:0] ch;
        if (a == b) begin
            ch = CH_C;
        end else if (a == c) begin
            ch = CH_B;
        end else begin
            ch = CH_A;
        end
        return ch;
    endfunction

endpackage

// File: rtl/tmr_input_conditioner_debounce_ch.sv
// One conditioning channel: two-flop synchroniser followed by a debounce
// counter that only accepts a level held for DEBOUNCE_CYCLES sample ticks.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic sample_en_i,
    output logic stable_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        // Idle clocks (no sample tick) leave the count untouched.
        if (sample_en_i) begin
            if (sync_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = sync_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/tmr_input_conditioner.sv
// Conditions three redundant raw inputs for a downstream majority voter and
// tracks disagreement between them, latching a sticky fault per channel.
module tmr_input_conditioner
    import tmr_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_THRESH    = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_raw,
    input  logic             b_raw,
    input  logic             c_raw,
    input  logic             sample_en,
    input  logic             clr,
    output logic             a_out,
    output logic             b_out,
    output logic             c_out,
    output logic             valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [2:0]       fault_ch
);

    localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int RUN_W  = $clog2(FAULT_THRESH + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(FAULT_THRESH);

    logic stable_a, stable_b, stable_c;

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .rst_n(rst_n), .raw_i(a_raw), .sample_en_i(sample_en), .stable_o(stable_a)
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .rst_n(rst_n), .raw_i(b_raw), .sample_en_i(sample_en), .stable_o(stable_b)
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
        .clk(clk), .rst_n(rst_n), .raw_i(c_raw), .sample_en_i(sample_en), .stable_o(stable_c)
    );

    state_e            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;

    // INIT waits long enough for every debouncer to have settled once.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (sample_en) begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    logic             all_eq;
    logic [1:0]       odd;
    logic             eval_tick;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [1:0]       prev_odd_q, prev_odd_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [2:0]       fault_q, fault_d;
    logic             mismatch_q, mismatch_d;

    assign all_eq    = (stable_a == stable_b) && (stable_b == stable_c);
    assign odd       = odd_channel(stable_a, stable_b, stable_c);
    assign eval_tick = (state_q == ST_RUN) && sample_en;

    always_comb begin
        run_cnt_d  = run_cnt_q;
        prev_odd_d = prev_odd_q;
        mcnt_d     = mcnt_q;
        fault_d    = fault_q;
        mismatch_d = (state_q == ST_RUN) && !all_eq;
        if (eval_tick) begin
            if (all_eq) begin
                run_cnt_d = '0;
            end else begin
                if ((odd == prev_odd_q) && (run_cnt_q != '0)) begin
                    if (run_cnt_q != RUN_MAX) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end else begin
                    run_cnt_d  = RUN_W'(1);
                    prev_odd_d = odd;
                end
                if (run_cnt_d == RUN_MAX) begin
                    fault_d[odd] = 1'b1;
                end
                if (mcnt_q != '1) begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
        end
        // Clear overrides any increment or fault set in the same cycle.
        if (clr) begin
            mcnt_d    = '0;
            fault_d   = '0;
            run_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            run_cnt_q  <= '0;
            prev_odd_q <= CH_A;
            mcnt_q     <= '0;
            fault_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            run_cnt_q  <= run_cnt_d;
            prev_odd_q <= prev_odd_d;
            mcnt_q     <= mcnt_d;
            fault_q    <= fault_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign a_out        = stable_a;
    assign b_out        = stable_b;
    assign c_out        = stable_c;
    assign valid        = (state_q == ST_RUN);
    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mcnt_q;
    assign fault_ch     = fault_q;

endmodule

// File: tb/tb_tmr_input_conditioner.sv
// Directed bench: two conditioners share the inputs, one with a small
// saturating counter and fault threshold 4, the other with threshold 5.
module tb_tmr_input_conditioner;

    logic clk = 1'b0;
    logic rst_n, a_raw, b_raw, c_raw, sample_en, clr;

    logic       a_out, b_out, c_out, valid, mismatch;
    logic [2:0] mismatch_cnt;
    logic [2:0] fault_ch;

    logic       alt_a_out, alt_b_out, alt_c_out, alt_valid, alt_mismatch;
    logic [7:0] alt_cnt;
    logic [2:0] alt_fault;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tmr_input_conditioner #(.DEBOUNCE_CYCLES(4), .FAULT_THRESH(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
        .sample_en(sample_en), .clr(clr), .a_out(a_out), .b_out(b_out), .c_out(c_out),
        .valid(valid), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt), .fault_ch(fault_ch)
    );

    tmr_input_conditioner #(.DEBOUNCE_CYCLES(4), .FAULT_THRESH(5), .CNT_W(8)) dut_alt (
        .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
        .sample_en(sample_en), .clr(clr), .a_out(alt_a_out), .b_out(alt_b_out), .c_out(alt_c_out),
        .valid(alt_valid), .mismatch(alt_mismatch), .mismatch_cnt(alt_cnt), .fault_ch(alt_fault)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_raw = 1'b0; b_raw = 1'b0; c_raw = 1'b0;
        sample_en = 1'b1; clr = 1'b0;
        tick(2);
        vectors++;
        if ({a_out, b_out, c_out, valid, mismatch, mismatch_cnt, fault_ch} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {a_out, b_out, c_out, valid, mismatch, mismatch_cnt, fault_ch}, 11'b0);
        end
        vectors++;
        if ({alt_a_out, alt_b_out, alt_c_out, alt_valid, alt_mismatch, alt_cnt, alt_fault} !== 16'b0) begin
            miscompares++;
            $display("FAIL reset_outputs_alt: got %b expected %b",
                     {alt_a_out, alt_b_out, alt_c_out, alt_valid, alt_mismatch, alt_cnt, alt_fault}, 16'b0);
        end
        rst_n = 1'b1;
        tick(5);
        vectors++;
        if ({valid, alt_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL init_valid_early: got %b expected %b", {valid, alt_valid}, 2'b00);
        end
        tick(1);
        vectors++;
        if ({valid, alt_valid, mismatch, mismatch_cnt, fault_ch} !== 9'b110_000_000) begin
            miscompares++;
            $display("FAIL init_valid_rise: got %b expected %b",
                     {valid, alt_valid, mismatch, mismatch_cnt, fault_ch}, 9'b110_000_000);
        end
    endtask

    task automatic test_debounce();
        {a_raw, b_raw, c_raw} = 3'b111;
        tick(5);
        vectors++;
        if ({a_out, b_out, c_out} !== 3'b000) begin
            miscompares++;
            $display("FAIL debounce_hold: got %b expected %b", {a_out, b_out, c_out}, 3'b000);
        end
        tick(1);
        vectors++;
        if ({a_out, b_out, c_out, alt_a_out} !== 4'b1111) begin
            miscompares++;
            $display("FAIL debounce_accept: got %b expected %b", {a_out, b_out, c_out, alt_a_out}, 4'b1111);
        end
        b_raw = 1'b0;
        tick(3);
        b_raw = 1'b1;
        tick(8);
        vectors++;
        if ({b_out, mismatch, mismatch_cnt} !== 5'b1_0_000) begin
            miscompares++;
            $display("FAIL glitch_filtered: got %b expected %b", {b_out, mismatch, mismatch_cnt}, 5'b10000);
        end
        {a_raw, b_raw, c_raw} = 3'b000;
        tick(6);
        vectors++;
        if ({a_out, b_out, c_out, mismatch} !== 4'b0000) begin
            miscompares++;
            $display("FAIL debounce_release: got %b expected %b", {a_out, b_out, c_out, mismatch}, 4'b0000);
        end
    endtask

    task automatic test_fault();
        c_raw = 1'b1;
        tick(6);
        vectors++;
        if ({c_out, mismatch, mismatch_cnt} !== 5'b1_0_000) begin
            miscompares++;
            $display("FAIL fault_c_rise: got %b expected %b", {c_out, mismatch, mismatch_cnt}, 5'b10000);
        end
        tick(1);
        vectors++;
        if ({mismatch, mismatch_cnt, alt_cnt, fault_ch} !== {1'b1, 3'd1, 8'd1, 3'b000}) begin
            miscompares++;
            $display("FAIL mismatch_first: got %b expected %b",
                     {mismatch, mismatch_cnt, alt_cnt, fault_ch}, {1'b1, 3'd1, 8'd1, 3'b000});
        end
        tick(2);
        vectors++;
        if ({mismatch_cnt, fault_ch} !== {3'd3, 3'b000}) begin
            miscompares++;
            $display("FAIL fault_before_thresh: got %b expected %b", {mismatch_cnt, fault_ch}, {3'd3, 3'b000});
        end
        tick(1);
        vectors++;
        if ({mismatch_cnt, fault_ch, alt_fault} !== {3'd4, 3'b100, 3'b000}) begin
            miscompares++;
            $display("FAIL fault_at_thresh: got %b expected %b",
                     {mismatch_cnt, fault_ch, alt_fault}, {3'd4, 3'b100, 3'b000});
        end
        tick(1);
        vectors++;
        if ({alt_fault, alt_cnt, mismatch_cnt} !== {3'b100, 8'd5, 3'd5}) begin
            miscompares++;
            $display("FAIL fault_alt_thresh: got %b expected %b",
                     {alt_fault, alt_cnt, mismatch_cnt}, {3'b100, 8'd5, 3'd5});
        end
        tick(5);
        vectors++;
        if ({mismatch_cnt, alt_cnt} !== {3'd7, 8'd10}) begin
            miscompares++;
            $display("FAIL cnt_saturate: got %0d/%0d expected 7/10", mismatch_cnt, alt_cnt);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        vectors++;
        if ({mismatch_cnt, fault_ch, alt_cnt, alt_fault} !== 17'b0) begin
            miscompares++;
            $display("FAIL clr_wins: got %b expected %b", {mismatch_cnt, fault_ch, alt_cnt, alt_fault}, 17'b0);
        end
        tick(3);
        vectors++;
        if ({mismatch_cnt, fault_ch} !== {3'd3, 3'b000}) begin
            miscompares++;
            $display("FAIL rerun_after_clr: got %b expected %b", {mismatch_cnt, fault_ch}, {3'd3, 3'b000});
        end
        tick(1);
        vectors++;
        if ({fault_ch, alt_cnt} !== {3'b100, 8'd4}) begin
            miscompares++;
            $display("FAIL fault_after_clr: got %b expected %b", {fault_ch, alt_cnt}, {3'b100, 8'd4});
        end
        c_raw = 1'b0;
        tick(7);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        vectors++;
        if ({c_out, mismatch, mismatch_cnt, fault_ch} !== 8'b0) begin
            miscompares++;
            $display("FAIL fault_clear_idle: got %b expected %b", {c_out, mismatch, mismatch_cnt, fault_ch}, 8'b0);
        end
    endtask

    // Odd channel swaps A -> B -> A; each run lasts four ticks, below the
    // alternate instance's threshold of five.
    task automatic test_alternate();
        a_raw = 1'b1;
        tick(6);
        sample_en = 1'b0; a_raw = 1'b0; b_raw = 1'b1;
        tick(3);
        sample_en = 1'b1;
        tick(4);
        vectors++;
        if ({a_out, b_out, fault_ch, alt_fault, alt_cnt} !== {2'b01, 3'b001, 3'b000, 8'd4}) begin
            miscompares++;
            $display("FAIL alt_phase_a: got %b expected %b",
                     {a_out, b_out, fault_ch, alt_fault, alt_cnt}, {2'b01, 3'b001, 3'b000, 8'd4});
        end
        sample_en = 1'b0; a_raw = 1'b1; b_raw = 1'b0;
        tick(3);
        sample_en = 1'b1;
        tick(4);
        vectors++;
        if ({a_out, b_out, fault_ch, alt_fault, alt_cnt, mismatch_cnt} !==
            {2'b10, 3'b011, 3'b000, 8'd8, 3'd7}) begin
            miscompares++;
            $display("FAIL alt_phase_b: got %b expected %b",
                     {a_out, b_out, fault_ch, alt_fault, alt_cnt, mismatch_cnt},
                     {2'b10, 3'b011, 3'b000, 8'd8, 3'd7});
        end
        sample_en = 1'b0; a_raw = 1'b0;
        tick(3);
        sample_en = 1'b1;
        tick(4);
        vectors++;
        if ({a_out, b_out, mismatch, alt_fault, alt_cnt} !== {2'b00, 1'b1, 3'b000, 8'd12}) begin
            miscompares++;
            $display("FAIL alt_phase_a2: got %b expected %b",
                     {a_out, b_out, mismatch, alt_fault, alt_cnt}, {2'b00, 1'b1, 3'b000, 8'd12});
        end
        tick(1);
        vectors++;
        if ({mismatch, alt_mismatch, alt_cnt} !== {2'b00, 8'd12}) begin
            miscompares++;
            $display("FAIL alt_settled: got %b expected %b", {mismatch, alt_mismatch, alt_cnt}, {2'b00, 8'd12});
        end
    endtask

    task automatic test_reset_mid();
        {a_raw, b_raw, c_raw} = 3'b111;
        tick(7);
        vectors++;
        if ({a_out, b_out, c_out, mismatch} !== 4'b1110) begin
            miscompares++;
            $display("FAIL pre_reset: got %b expected %b", {a_out, b_out, c_out, mismatch}, 4'b1110);
        end
        a_raw = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        vectors++;
        if ({a_out, b_out, c_out, valid, mismatch, mismatch_cnt, fault_ch, alt_fault, alt_cnt} !== 22'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got %b expected %b",
                     {a_out, b_out, c_out, valid, mismatch, mismatch_cnt, fault_ch, alt_fault, alt_cnt}, 22'b0);
        end
        tick(5);
        vectors++;
        if ({valid, b_out, c_out} !== 3'b000) begin
            miscompares++;
            $display("FAIL reinit_early: got %b expected %b", {valid, b_out, c_out}, 3'b000);
        end
        tick(1);
        vectors++;
        if ({valid, a_out, b_out, c_out, mismatch, mismatch_cnt} !== 8'b1_011_0_000) begin
            miscompares++;
            $display("FAIL reinit_run: got %b expected %b",
                     {valid, a_out, b_out, c_out, mismatch, mismatch_cnt}, 8'b10110000);
        end
        tick(1);
        vectors++;
        if ({mismatch, mismatch_cnt, alt_cnt} !== {1'b1, 3'd1, 8'd1}) begin
            miscompares++;
            $display("FAIL reinit_mismatch: got %b expected %b",
                     {mismatch, mismatch_cnt, alt_cnt}, {1'b1, 3'd1, 8'd1});
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_fault();
        test_alternate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
